// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Summary  : Round-robin arbiter and burst sequencer. It shares one
//            single-port memory among NREQ requesters, issuing either a
//            strided read burst of 1..4 beats or a single-word write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NREQ   = 4,
    parameter int STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*32-1:0]   adr,
    input  logic [NREQ*32-1:0]   wdata,
    input  logic [NREQ*2-1:0]    len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic [31:0]          mem_adr,
    output logic [31:0]          mem_in,
    output logic                 mem_we,
    input  logic [31:0]          mem_out
);

    localparam int          c_GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] c_STRIDE = 32'(STRIDE);
    localparam logic [31:0] c_NREQ   = 32'(NREQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_GW-1:0] r_ptr, w_ptr_nxt;
    logic [1:0]      r_beat, w_beat_nxt;
    logic [1:0]      r_last, w_last_nxt;
    logic [31:0]     r_base, w_base_nxt;
    logic [31:0]     r_wdata, w_wdata_nxt;
    logic            r_we, w_we_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_rvalid, w_rvalid_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [31:0]     r_rdata, w_rdata_nxt;

    logic            w_any;
    logic [c_GW-1:0] w_win;
    logic [c_GW-1:0] w_idx;
    logic [31:0]     w_sum;
    logic [c_GW-1:0] w_ptr_inc;
    logic            w_busy;
    logic [31:0]     w_beat_adr;

    // Round-robin search: walk downward so the candidate closest to the
    // pointer is assigned last and therefore wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        w_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum = 32'(r_ptr) + 32'(i);
            w_idx = c_GW'(w_sum % c_NREQ);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Pointer moves one past the winner, wrapping at NREQ.
    assign w_ptr_inc  = ((32'(w_win) + 32'd1) == c_NREQ) ? '0 : w_win + 1'b1;

    assign w_busy     = (r_state == S_BUSY);
    assign w_beat_adr = r_base + (32'(r_beat) * c_STRIDE);

    // Memory port is quiet outside BUSY; a write is never issued under reset.
    assign mem_adr = w_busy ? w_beat_adr : '0;
    assign mem_in  = w_busy ? r_wdata : '0;
    assign mem_we  = w_busy & r_we & ~rst;

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign done   = r_done;
    assign rdata  = r_rdata;

    // Next-state and registered-output logic of the IDLE/BUSY sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_beat_nxt   = r_beat;
        w_last_nxt   = r_last;
        w_base_nxt   = r_base;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = r_we;
        w_gnt_nxt    = r_gnt;
        w_rvalid_nxt = '0;
        w_done_nxt   = '0;
        w_rdata_nxt  = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt      = S_BUSY;
                    w_ptr_nxt        = w_ptr_inc;
                    w_base_nxt       = adr[32*w_win +: 32];
                    w_wdata_nxt      = wdata[32*w_win +: 32];
                    w_we_nxt         = we[w_win];
                    w_last_nxt       = we[w_win] ? 2'd0 : len[2*w_win +: 2];
                    w_beat_nxt       = 2'd0;
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_win] = 1'b1;
                end
            end
            S_BUSY: begin
                // r_gnt is the one-hot of the current owner.
                if (!r_we) begin
                    w_rdata_nxt  = mem_out;
                    w_rvalid_nxt = r_gnt;
                end
                if (r_beat == r_last) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_done_nxt  = r_gnt;
                end else begin
                    w_beat_nxt = r_beat + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst without signalling done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_beat   <= 2'd0;
            r_last   <= 2'd0;
            r_base   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_beat   <= w_beat_nxt;
            r_last   <= w_last_nxt;
            r_base   <= w_base_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_done   <= w_done_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

endmodule
`default_nettype wire
